// File: rtl/data_ram_ctrl_pkg.sv
// Shared constants, FSM state type and address range helper for the data-side RAM controller.
package data_ram_ctrl_pkg;

  localparam logic RSTN_ENABLE       = 1'b0;
  localparam logic CHIP_ENABLE       = 1'b1;
  localparam logic WRITE_ENABLE      = 1'b1;
  localparam int   DATA_W            = 32;
  localparam int   DATA_MEM_NUM_LOG2 = 17;
  localparam int   BYTE_SEL_W        = 4;
  localparam int   CNT_W             = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // A byte address is valid only if every bit above the word index is clear.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Request/response bundle between the memory-access stage and the data RAM controller.
interface data_ram_ctrl_if;
  import data_ram_ctrl_pkg::*;

  logic                  ce_i;
  logic                  we_i;
  logic [31:0]           addr_i;
  logic [BYTE_SEL_W-1:0] sel_i;
  logic [DATA_W-1:0]     data_i;
  logic [DATA_W-1:0]     data_o;
  logic                  stallreq_o;
  logic                  ack_o;
  logic                  err_o;
  logic [31:0]           rd_count_o;
  logic [31:0]           wr_count_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, stallreq_o, ack_o, err_o, rd_count_o, wr_count_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, stallreq_o, ack_o, err_o, rd_count_o, wr_count_o
  );

endinterface

// File: rtl/data_ram_array.sv
// Word storage split into byte lanes: per-lane synchronous write, asynchronous full-word read.
module data_ram_array
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DATA_MEM_NUM_LOG2
) (
  input  logic                  clk,
  input  logic [BYTE_SEL_W-1:0] we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  // One array per lane keeps each byte write enable independent of the others.
  for (genvar gi = 0; gi < BYTE_SEL_W; gi++) begin : g_lane
    logic [7:0] lane_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        lane_mem[addr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM responder: wait-state FSM, range check, byte-lane writes and access counters.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DATA_MEM_NUM_LOG2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  data_ram_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [31:0]           rd_count_reg, wr_count_reg;
  logic                  stall_next, done_next;
  logic                  rst_active, req, is_write, in_range;
  logic [BYTE_SEL_W-1:0] byte_we;
  logic [DATA_W-1:0]     rdata;

  assign rst_active = (rst == RSTN_ENABLE);
  assign req        = (bus.ce_i == CHIP_ENABLE);
  assign is_write   = (bus.we_i == WRITE_ENABLE);
  assign in_range   = addr_in_range(bus.addr_i, ADDR_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_next = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            done_next = 1'b1;
          end else begin
            stall_next = 1'b1;
            cnt_next   = WAIT_LOAD;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Dropping ce_i mid-sequence is a pipeline flush: abandon the access silently.
        if (!req) begin
          state_next = ST_IDLE;
        end else if (cnt_reg != '0) begin
          stall_next = 1'b1;
          cnt_next   = cnt_reg - 1'b1;
        end else begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // The outputs are combinational from ce_i, so hold them quiet while reset is low.
    if (rst_active) begin
      stall_next = 1'b0;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else if (done_next) begin
      if (is_write) begin
        wr_count_reg <= wr_count_reg + 32'd1;
      end else begin
        rd_count_reg <= rd_count_reg + 32'd1;
      end
    end
  end

  assign byte_we = (done_next && is_write && in_range) ? bus.sel_i : '0;

  data_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (byte_we),
    .addr  (bus.addr_i[ADDR_W+1:2]),
    .wdata (bus.data_i),
    .rdata (rdata)
  );

  assign bus.data_o     = (!rst_active && req && !is_write && in_range) ? rdata : '0;
  assign bus.stallreq_o = stall_next;
  assign bus.ack_o      = done_next;
  assign bus.err_o      = done_next && !in_range;
  assign bus.rd_count_o = rd_count_reg;
  assign bus.wr_count_o = wr_count_reg;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench: four controller instances with different wait-state and depth settings.
module tb_data_ram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_ram_ctrl_if bus0();
  data_ram_ctrl_if bus1();
  data_ram_ctrl_if bus2();
  data_ram_ctrl_if bus3();

  data_ram_ctrl #(.ADDR_W(17), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  data_ram_ctrl #(.ADDR_W(4),  .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  data_ram_ctrl #(.ADDR_W(8),  .WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  data_ram_ctrl #(.ADDR_W(8),  .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    int          stalls;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic ce, input logic we,
                       input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
    case (which)
      0: begin bus0.ce_i = ce; bus0.we_i = we; bus0.addr_i = addr; bus0.sel_i = sel; bus0.data_i = data; end
      1: begin bus1.ce_i = ce; bus1.we_i = we; bus1.addr_i = addr; bus1.sel_i = sel; bus1.data_i = data; end
      2: begin bus2.ce_i = ce; bus2.we_i = we; bus2.addr_i = addr; bus2.sel_i = sel; bus2.data_i = data; end
      default: begin bus3.ce_i = ce; bus3.we_i = we; bus3.addr_i = addr; bus3.sel_i = sel; bus3.data_i = data; end
    endcase
  endtask

  task automatic sample(input int which, output logic st, output logic ak, output logic er,
                        output logic [31:0] dat, output logic [31:0] rdc, output logic [31:0] wrc);
    case (which)
      0: begin st = bus0.stallreq_o; ak = bus0.ack_o; er = bus0.err_o; dat = bus0.data_o; rdc = bus0.rd_count_o; wrc = bus0.wr_count_o; end
      1: begin st = bus1.stallreq_o; ak = bus1.ack_o; er = bus1.err_o; dat = bus1.data_o; rdc = bus1.rd_count_o; wrc = bus1.wr_count_o; end
      2: begin st = bus2.stallreq_o; ak = bus2.ack_o; er = bus2.err_o; dat = bus2.data_o; rdc = bus2.rd_count_o; wrc = bus2.wr_count_o; end
      default: begin st = bus3.stallreq_o; ak = bus3.ack_o; er = bus3.err_o; dat = bus3.data_o; rdc = bus3.rd_count_o; wrc = bus3.wr_count_o; end
    endcase
  endtask

  // Called just after a rising edge; returns just after the edge that closes the ack cycle.
  task automatic access(input int which, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data, input int stalls, input logic [31:0] exp_data,
                        input logic exp_err, input string name);
    exp_t e;
    logic st, ak, er;
    logic [31:0] dat, rdc, wrc;
    int n = 0;
    bit got = 0;
    e = '{name, stalls, exp_data, exp_err};
    sb.push_back(e);
    drive(which, 1'b1, we, addr, sel, data);
    for (int c = 0; c < 32 && !got; c++) begin
      @(negedge clk);
      sample(which, st, ak, er, dat, rdc, wrc);
      if (ak) begin
        got = 1;
        e = sb.pop_front();
        check({e.name, "_stalls"}, 32'(n), 32'(e.stalls));
        check({e.name, "_data"}, dat, e.data);
        check({e.name, "_err"}, 32'(er), 32'(e.err));
        $display("txn %s: dut%0d we=%0d addr=%h sel=%b data_o=%h err=%0d stalls=%0d",
                 e.name, which, we, addr, sel, dat, er, n);
      end else if (st) begin
        n++;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_timeout: ack got 0 expected 1", e.name);
    end
    drive(which, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Holds a request for 'hold' stall cycles, then drops ce_i and checks the flush cycle.
  task automatic abort_access(input int which, input logic we, input logic [31:0] addr,
                              input logic [31:0] data, input int hold, input string name);
    logic st, ak, er;
    logic [31:0] dat, rdc, wrc;
    drive(which, 1'b1, we, addr, 4'hF, data);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      sample(which, st, ak, er, dat, rdc, wrc);
      check($sformatf("%s_stall%0d", name, c), 32'(st), 32'd1);
      @(posedge clk); #1;
    end
    drive(which, 1'b0, we, addr, 4'hF, data);
    @(negedge clk);
    sample(which, st, ak, er, dat, rdc, wrc);
    check({name, "_flush_stall"}, 32'(st), 32'd0);
    check({name, "_flush_ack"}, 32'(ak), 32'd0);
    $display("txn %s: dut%0d aborted after %0d stall cycles", name, which, hold);
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input int which, input logic [31:0] rd_exp, input logic [31:0] wr_exp,
                              input string name);
    logic st, ak, er;
    logic [31:0] dat, rdc, wrc;
    sample(which, st, ak, er, dat, rdc, wrc);
    check({name, "_rd_count"}, rdc, rd_exp);
    check({name, "_wr_count"}, wrc, wr_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st, ak, er;
    logic [31:0] dat, rdc, wrc;
    int n_wr = 0;
    int n_rd = 0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0011, 4'b0100, 32'hABAB_ABAB, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0000_0000, 32'h12AB_5678, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0013, 4'b0001, 32'h0000_0000, 32'h12AB_5678, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0040, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0040, 4'b1001, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0040, 4'b1111, 32'h0000_0000, 32'hA100_00D4, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0044, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0040, 4'b1111, 32'h0000_0000, 32'hA100_00D4, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0040, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0040, 4'b1111, 32'h0000_0000, 32'hA100_00D4, 1'b0};
    vecs[13] = '{1'b0, 32'h0080_0000, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b1, 32'h0100_0000, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1};

    // Reset with live requests: everything must stay quiet.
    drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h0, 4'hF, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    sample(0, st, ak, er, dat, rdc, wrc);
    check("rst_dut0_stall", 32'(st), 32'd0);
    check("rst_dut0_ack", 32'(ak), 32'd0);
    check("rst_dut0_err", 32'(er), 32'd0);
    check("rst_dut0_data", dat, 32'h0);
    check_counts(0, 32'd0, 32'd0, "rst_dut0");
    sample(1, st, ak, er, dat, rdc, wrc);
    check("rst_dut1_stall", 32'(st), 32'd0);
    check("rst_dut1_ack", 32'(ak), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-wait instance driven from the vector table, back to back.
    for (int i = 0; i < 15; i++) begin
      access(0, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data, 0,
             vecs[i].exp_data, vecs[i].exp_err, $sformatf("t1_v%0d", i));
      if (vecs[i].we) n_wr++;
      else n_rd++;
    end
    check_counts(0, 32'(n_rd), 32'(n_wr), "t1_end");

    // Write counter wrap and an empty byte select.
    force u_dut0.wr_count_reg = 32'hFFFF_FFFF;
    @(negedge clk);
    release u_dut0.wr_count_reg;
    check_counts(0, 32'(n_rd), 32'hFFFF_FFFF, "t6_preload");
    @(posedge clk); #1;
    access(0, 1'b1, 32'h44, 4'b0000, 32'h0000_0000, 0, 32'h0, 1'b0, "t6_wrap_wr");
    check_counts(0, 32'(n_rd), 32'h0, "t6_wrap");
    access(0, 1'b0, 32'h44, 4'b1111, 32'h0, 0, 32'hCAFE_F00D, 1'b0, "t6_rd");

    // Two wait states, byte-lane merge.
    access(2, 1'b1, 32'h10, 4'b1111, 32'h1234_5678, 2, 32'h0, 1'b0, "t2_wr_word");
    access(2, 1'b1, 32'h11, 4'b0100, 32'hABAB_ABAB, 2, 32'h0, 1'b0, "t2_wr_byte");
    access(2, 1'b0, 32'h10, 4'b1111, 32'h0, 2, 32'h12AB_5678, 1'b0, "t2_rd");
    check_counts(2, 32'd1, 32'd2, "t2_end");

    // Three wait states with flushed read and write.
    access(3, 1'b1, 32'h20, 4'b1111, 32'h5555_AAAA, 3, 32'h0, 1'b0, "t3_wr");
    abort_access(3, 1'b0, 32'h20, 32'h0, 2, "t3_abort_rd");
    check_counts(3, 32'd0, 32'd1, "t3_after_rd_abort");
    abort_access(3, 1'b1, 32'h20, 32'h0, 3, "t3_abort_wr");
    check_counts(3, 32'd0, 32'd1, "t3_after_wr_abort");
    access(3, 1'b0, 32'h20, 4'b1111, 32'h0, 3, 32'h5555_AAAA, 1'b0, "t3_rd");
    check_counts(3, 32'd1, 32'd1, "t3_end");

    // Out-of-range accesses on the 16-word instance; 0x100 aliases word 0 if unchecked.
    access(1, 1'b1, 32'h0, 4'b1111, 32'h1357_2468, 1, 32'h0, 1'b0, "t4_wr");
    access(1, 1'b1, 32'h100, 4'b1111, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, "t4_wr_oor");
    access(1, 1'b0, 32'h0, 4'b1111, 32'h0, 1, 32'h1357_2468, 1'b0, "t4_rd");
    access(1, 1'b0, 32'h40, 4'b1111, 32'h0, 1, 32'h0, 1'b1, "t4_rd_oor");
    check_counts(1, 32'd2, 32'd2, "t4_end");

    // Reset asserted during the completion cycle of a write.
    access(1, 1'b1, 32'h20, 4'b1111, 32'h0BAD_BEEF, 1, 32'h0, 1'b0, "t5_wr");
    drive(1, 1'b1, 1'b1, 32'h20, 4'hF, 32'h1111_1111);
    @(negedge clk);
    sample(1, st, ak, er, dat, rdc, wrc);
    check("t5_stall", 32'(st), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    sample(1, st, ak, er, dat, rdc, wrc);
    check("t5_rst_stall", 32'(st), 32'd0);
    check("t5_rst_ack", 32'(ak), 32'd0);
    check("t5_rst_err", 32'(er), 32'd0);
    check_counts(1, 32'd0, 32'd0, "t5_rst");
    check_counts(0, 32'd0, 32'd0, "t5_rst_dut0");
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    access(1, 1'b0, 32'h20, 4'b1111, 32'h0, 1, 32'h0BAD_BEEF, 1'b0, "t5_rd");
    check_counts(1, 32'd1, 32'd0, "t5_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
Data-side RAM responder for the pipeline's memory-access stage. It accepts the stage's word-addressed request bundle (chip enable, write enable, byte select, address, write data) and services it from an internal word array, with byte-lane writes and full-word reads. A programmable number of wait states is inserted through a stall request to the pipeline controller. Read and write access counters are exposed for performance monitoring.

Parameters:
ADDR_W, 17, number of word-address bits; array depth is 2**ADDR_W words.
WAIT_CYCLES, 1, stall cycles inserted per access; 0 to 15.

Ports:
clk  in  1  clock.
rst  in  1  reset; one clock, asynchronous, active-low (rst==0 resets).
ce_i  in  1  chip enable; an access is requested while 1.
we_i  in  1  1=write, 0=read.
addr_i  in  32  byte address; bits [1:0] are ignored by the array.
sel_i  in  4  byte lanes, big-endian: sel[3]=data[31:24] (offset 0), sel[0]=data[7:0] (offset 3).
data_i  in  32  write data, already replicated onto lanes by the requester.
data_o  out  32  read data, full word, unmasked.
stallreq_o  out  1  hold-pipeline request.
ack_o  out  1  access completes this cycle.
err_o  out  1  address out of range on the completing cycle.
rd_count_o  out  32  completed reads; wraps at 2**32.
wr_count_o  out  32  completed writes; wraps at 2**32.

Behaviour:
- Reset (rst==0, async): state IDLE, wait counter 0, both access counters 0. stallreq_o, ack_o and err_o are 0, and data_o is 0 while reset is asserted. Array contents are not reset.
- FSM states are IDLE and WAIT. The wait counter cnt is 4 bits.
- IDLE with ce_i=0:
  - No activity.
  - stallreq_o=0, ack_o=0.
- IDLE with ce_i=1 and WAIT_CYCLES==0:
  - The access completes in the same cycle: stallreq_o=0, ack_o=1.
  - A write commits at the closing clock edge.
- IDLE with ce_i=1 and WAIT_CYCLES>0:
  - stallreq_o=1, ack_o=0.
  - cnt<=WAIT_CYCLES-1, go to WAIT.
- WAIT with ce_i=1 and cnt!=0:
  - stallreq_o=1, cnt<=cnt-1.
- WAIT with ce_i=1 and cnt==0:
  - Completion cycle: stallreq_o=0, ack_o=1.
  - A write commits at the closing edge.
  - Go to IDLE.
- WAIT with ce_i=0 (flush):
  - The access is aborted: no write, ack_o=0, stallreq_o=0.
  - Go to IDLE. Counters are unchanged.
- Latency: exactly WAIT_CYCLES stall cycles per access.
- The requester holds ce_i, we_i, addr_i, sel_i and data_i stable while stallreq_o=1. Request changes inside WAIT are not detected, apart from ce_i.
- Back-to-back accesses:
  - After a completion the FSM is in IDLE.
  - If ce_i is still 1 on the next cycle, that is a new access and starts a new stall sequence.
- Read data:
  - data_o = mem[addr_i[ADDR_W+1:2]], combinational, whenever ce_i=1, we_i=0 and the address is in range.
  - Otherwise data_o=0.
  - The value is valid for the requester on the ack_o cycle.
- Write data:
  - For each lane with sel_i[k]=1, that byte of data_i is written at the edge ending the ack cycle.
  - sel_i=0000 writes nothing, but still acks and still increments wr_count_o.
- Read after write: an access following a completed write to the same word observes the new bytes.
- Range check:
  - An address is out of range when addr_i[31:ADDR_W+2] != 0.
  - On the completion cycle of such an access: err_o=1, ack_o=1, the write is suppressed, data_o=0, and counters still increment.
  - err_o=0 on all other cycles.
- Counters: rd_count_o or wr_count_o increments by 1 at the edge ending each ack cycle, selected by we_i, and wraps to 0.
- Reset mid-access: the FSM returns to IDLE immediately, the pending write is lost, and the counters are cleared.

Decomposition:
- Shared defines include: `RstnEnable (1'b0), `ChipEnable, `WriteEnable, `DataBus (31:0), `DataMemNumLog2 (the default for ADDR_W), and the ByteSel width (4).
- One sub-module, data_ram_array:
  - Holds 2**ADDR_W x 32 storage.
  - 4 byte-write enables.
  - Asynchronous read port, synchronous write port.
- The FSM, range check and counters live in data_ram_ctrl.

Test Plan:
1. WAIT_CYCLES=0; write addr=0x00000010, sel=1111, data=0x12345678; then read 0x10 -> no stall; ack_o=1 each cycle; data_o=0x12345678; wr_count_o=1, rd_count_o=1.
2. WAIT_CYCLES=2; sb-style write addr=0x11, sel=0100, data=0xABABABAB over word 0x12345678; then read 0x10 -> stallreq_o high for 2 cycles per access, ack_o on cycle 2; data_o=0x12AB5678.
3. WAIT_CYCLES=3; read starts, ce_i dropped in the second WAIT cycle -> no ack; FSM returns to IDLE; rd_count_o unchanged; next access again stalls 3 cycles.
4. ADDR_W=4; write addr=0x00000100, data=0xFFFFFFFF -> err_o=1 with ack_o; no array word changes (readback of 0x0 still returns its previous value); wr_count_o increments.
5. WAIT_CYCLES=1; rst pulled low during WAIT of a write to 0x20 -> outputs 0 immediately; counters 0; word 0x20 unchanged after release; first post-reset access stalls exactly 1 cycle.
6. Preload wr_count_o to 0xFFFFFFFF via 2**32-1 writes (or force); one more write -> wr_count_o=0x00000000; sel=0000 write leaves data unchanged but counts.
